mtl_panel_sequencer: RTL and testbench

//  Power/reset/backlight sequencer for the MTL2 LCD panel driven by the video timing path.

---
 rtl/mtl_panel_pkg.sv | 34 +++
 rtl/mtl_panel_sequencer_pwm.sv | 81 ++++++++
 rtl/mtl_panel_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_mtl_panel_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtl_panel_pkg.sv
// mtl_panel_pkg: shared definitions for the MTL2 panel sequencer.
//   - S_OFF..S_PWR_DN : 3-bit state encodings (also visible on state_o)
//   - state_t         : FSM state type built on those encodings
//   - PWM_W           : backlight PWM counter / level width
//   - ms2cyc()        : milliseconds -> clock cycles for a given clock rate
package mtl_panel_pkg;

  localparam logic [2:0] S_OFF     = 3'd0;
  localparam logic [2:0] S_PWR_UP  = 3'd1;
  localparam logic [2:0] S_RST_REL = 3'd2;
  localparam logic [2:0] S_VID_ON  = 3'd3;
  localparam logic [2:0] S_BL_ON   = 3'd4;
  localparam logic [2:0] S_BL_OFF  = 3'd5;
  localparam logic [2:0] S_VID_OFF = 3'd6;
  localparam logic [2:0] S_PWR_DN  = 3'd7;

  typedef enum logic [2:0] {
    ST_OFF     = S_OFF,
    ST_PWR_UP  = S_PWR_UP,
    ST_RST_REL = S_RST_REL,
    ST_VID_ON  = S_VID_ON,
    ST_BL_ON   = S_BL_ON,
    ST_BL_OFF  = S_BL_OFF,
    ST_VID_OFF = S_VID_OFF,
    ST_PWR_DN  = S_PWR_DN
  } state_t;

  localparam int unsigned PWM_W = 8;

  function automatic logic [31:0] ms2cyc(input int unsigned ms, input int unsigned clk_hz);
    return 32'(ms * (clk_hz / 1000));
  endfunction

endpackage

// File: rtl/mtl_panel_sequencer_pwm.sv
// mtl_bl_pwm: backlight PWM generator for LCD_DIM.
//   Prescaler counts 0..PWM_PRESCALE-1; the 8-bit period counter advances on
//   each prescaler wrap. The effective level is only updated when the period
//   counter wraps 255->0, so a period never mixes two duty values.
//   Optional feature macro: MTL_BL_SOFT_RAMP_EN -- the effective level steps
//   by +/-1 per period toward 'level' and is held at 0 while 'en' is low.
// Ports:
//   clk_50      in   system clock
//   reset_n     in   synchronous active-low reset
//   en          in   output enable (registered by the caller)
//   level       in   requested duty, duty = level/256
//   dim         out  PWM output, gated by en
//   period_end  out  high for the cycle in which the period counter wraps
//   at_zero     out  effective level is 0
module mtl_bl_pwm
  import mtl_panel_pkg::*;
#(
  parameter int unsigned PWM_PRESCALE = 10
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             en,
  input  logic [PWM_W-1:0] level,
  output logic             dim,
  output logic             period_end,
  output logic             at_zero
);

  localparam int unsigned PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  logic [PRE_W-1:0] r_pre;
  logic [PWM_W-1:0] r_pcnt;
  logic [PWM_W-1:0] r_lvl;
  logic             r_raw;

  logic             w_tick;
  logic             w_wrap;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [PWM_W-1:0] w_pcnt_nxt;
  logic [PWM_W-1:0] w_lvl_nxt;

  assign w_tick = (r_pre == PRE_W'(PWM_PRESCALE - 1));
  assign w_wrap = w_tick && (r_pcnt == '1);

  always_comb begin
    w_pre_nxt  = w_tick ? '0 : r_pre + PRE_W'(1);
    w_pcnt_nxt = w_tick ? r_pcnt + PWM_W'(1) : r_pcnt;
    w_lvl_nxt  = r_lvl;
`ifdef MTL_BL_SOFT_RAMP_EN
    if (!en) begin
      w_lvl_nxt = '0;
    end else if (w_wrap) begin
      if (r_lvl < level)      w_lvl_nxt = r_lvl + PWM_W'(1);
      else if (r_lvl > level) w_lvl_nxt = r_lvl - PWM_W'(1);
    end
`else
    if (w_wrap) w_lvl_nxt = level;
`endif
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_pre  <= '0;
      r_pcnt <= '0;
      r_lvl  <= '0;
      r_raw  <= 1'b0;
    end else begin
      r_pre  <= w_pre_nxt;
      r_pcnt <= w_pcnt_nxt;
      r_lvl  <= w_lvl_nxt;
      // Compare on the next-state values so r_raw always matches the
      // counter/level pair now held in the registers.
      r_raw  <= (w_pcnt_nxt < w_lvl_nxt);
    end
  end

  assign dim        = en & r_raw;
  assign period_end = w_wrap;
  assign at_zero    = (r_lvl == '0);

endmodule

// File: rtl/mtl_panel_sequencer.sv
// mtl_panel_sequencer: power / reset / backlight sequencer for the MTL2 LCD.
//   Bring-up order: power -> reset release -> video enable -> backlight,
//   teardown in reverse. Each timed state dwells exactly T_x ms.
//   Optional feature macro: MTL_BL_SOFT_RAMP_EN -- backlight ramps up on
//   BL_ON entry and ramps down to 0 in BL_OFF before its dwell starts.
// Ports:
//   clk_50         in   system clock
//   reset_n        in   synchronous active-low reset
//   panel_en       in   level request: 1 = panel on
//   vid_locked     in   video PLL locked / pixel clock valid
//   bl_level[7:0]  in   backlight duty request
//   lcd_power_ctl  out  panel supply enable
//   lcd_rstb       out  panel reset, active low
//   lcd_dim        out  backlight PWM
//   video_gate     out  1 = drive LCD sync/data
//   panel_ready    out  1 only in BL_ON
//   fault          out  sticky: vid_locked dropped while video was gated on
//   state_o[2:0]   out  current state encoding
module mtl_panel_sequencer
  import mtl_panel_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned T_PWR_MS     = 20,
  parameter int unsigned T_RST_MS     = 10,
  parameter int unsigned T_VID_MS     = 50,
  parameter int unsigned PWM_PRESCALE = 10
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       panel_en,
  input  logic       vid_locked,
  input  logic [7:0] bl_level,
  output logic       lcd_power_ctl,
  output logic       lcd_rstb,
  output logic       lcd_dim,
  output logic       video_gate,
  output logic       panel_ready,
  output logic       fault,
  output logic [2:0] state_o
);

  // Timer reload values: a state entered with N-1 leaves after N cycles.
  localparam logic [31:0] L_PWR = ms2cyc(T_PWR_MS, CLK_HZ) - 32'd1;
  localparam logic [31:0] L_RST = ms2cyc(T_RST_MS, CLK_HZ) - 32'd1;
  localparam logic [31:0] L_VID = ms2cyc(T_VID_MS, CLK_HZ) - 32'd1;

  state_t      r_state;
  logic [31:0] r_timer;
  logic        r_pwr;
  logic        r_rstb;
  logic        r_gate;
  logic        r_ready;
  logic        r_fault;
  logic        r_dim_en;
  logic        r_bl_ramp;

  logic        w_abort;
  logic        w_tdone;
  logic [7:0]  w_level;
  logic        w_dim;
  logic        w_period_end;
  logic        w_at_zero;
  logic        w_pwm_frame_unused;

  assign w_abort = !panel_en || !vid_locked;
  assign w_tdone = (r_timer == 32'd0);
  // Outside BL_ON the requested level is 0, which is what the ramp-down aims for.
  assign w_level = (r_state == ST_BL_ON) ? bl_level : 8'd0;

  // The sequencer has no use for the PWM frame strobe.
  assign w_pwm_frame_unused = w_period_end;

  mtl_bl_pwm #(.PWM_PRESCALE(PWM_PRESCALE)) u_pwm (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .en         (r_dim_en),
    .level      (w_level),
    .dim        (w_dim),
    .period_end (w_period_end),
    .at_zero    (w_at_zero)
  );

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_state   <= ST_OFF;
      r_timer   <= 32'd0;
      r_pwr     <= 1'b0;
      r_rstb    <= 1'b0;
      r_gate    <= 1'b0;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
      r_dim_en  <= 1'b0;
      r_bl_ramp <= 1'b0;
    end else begin
      if (!vid_locked && r_gate) r_fault <= 1'b1;
      if (!w_tdone) r_timer <= r_timer - 32'd1;

      // Abort checks precede timer expiry so an abort wins a same-cycle tie.
      case (r_state)
        ST_OFF: begin
          if (!panel_en) begin
            r_fault <= 1'b0;
          end else if (vid_locked && !r_fault) begin
            r_state <= ST_PWR_UP;
            r_pwr   <= 1'b1;
            r_timer <= L_PWR;
          end
        end
        ST_PWR_UP: begin
          if (w_abort) begin
            r_state <= ST_PWR_DN;
            r_pwr   <= 1'b0;
            r_timer <= L_PWR;
          end else if (w_tdone) begin
            r_state <= ST_RST_REL;
            r_rstb  <= 1'b1;
            r_timer <= L_RST;
          end
        end
        ST_RST_REL: begin
          if (w_abort) begin
            r_state <= ST_PWR_DN;
            r_pwr   <= 1'b0;
            r_rstb  <= 1'b0;
            r_timer <= L_PWR;
          end else if (w_tdone) begin
            r_state <= ST_VID_ON;
            r_gate  <= 1'b1;
            r_timer <= L_VID;
          end
        end
        ST_VID_ON: begin
          if (w_abort) begin
            r_state <= ST_VID_OFF;
            r_gate  <= 1'b0;
            r_rstb  <= 1'b0;
            r_timer <= L_RST;
          end else if (w_tdone) begin
            r_state  <= ST_BL_ON;
            r_ready  <= 1'b1;
            r_dim_en <= 1'b1;
          end
        end
        ST_BL_ON: begin
          if (w_abort) begin
            r_state <= ST_BL_OFF;
            r_ready <= 1'b0;
`ifdef MTL_BL_SOFT_RAMP_EN
            // Already dark: skip the ramp and start the dwell straight away.
            if (w_at_zero) begin
              r_dim_en <= 1'b0;
              r_timer  <= L_VID;
            end else begin
              r_bl_ramp <= 1'b1;
            end
`else
            r_dim_en <= 1'b0;
            r_timer  <= L_VID;
`endif
          end
        end
        ST_BL_OFF: begin
          // During the ramp the PWM stays live and the timer idles at 0.
          if (r_bl_ramp) begin
            if (w_at_zero) begin
              r_bl_ramp <= 1'b0;
              r_dim_en  <= 1'b0;
              r_timer   <= L_VID;
            end
          end else if (w_tdone) begin
            r_state <= ST_VID_OFF;
            r_gate  <= 1'b0;
            r_rstb  <= 1'b0;
            r_timer <= L_RST;
          end
        end
        ST_VID_OFF: begin
          if (w_tdone) begin
            r_state <= ST_PWR_DN;
            r_pwr   <= 1'b0;
            r_timer <= L_PWR;
          end
        end
        ST_PWR_DN: begin
          if (w_tdone) r_state <= ST_OFF;
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign lcd_power_ctl = r_pwr;
  assign lcd_rstb      = r_rstb;
  assign video_gate    = r_gate;
  assign panel_ready   = r_ready;
  assign fault         = r_fault;
  assign state_o       = r_state;
  // AND of two registers: r_dim_en and the PWM compare flop.
  assign lcd_dim       = w_dim;

endmodule

// File: tb/tb_mtl_panel_sequencer.sv
module tb_mtl_panel_sequencer;

  logic       clk_50 = 1'b0;
  logic       reset_n;
  logic       panel_en;
  logic       vid_locked;
  logic [7:0] bl_level;
  logic       lcd_power_ctl, lcd_rstb, lcd_dim, video_gate, panel_ready, fault;
  logic [2:0] state_o;

  always #5 clk_50 = ~clk_50;

  mtl_panel_sequencer #(
    .CLK_HZ(10_000), .T_PWR_MS(2), .T_RST_MS(1), .T_VID_MS(3), .PWM_PRESCALE(1)
  ) dut (
    .clk_50        (clk_50),
    .reset_n       (reset_n),
    .panel_en      (panel_en),
    .vid_locked    (vid_locked),
    .bl_level      (bl_level),
    .lcd_power_ctl (lcd_power_ctl),
    .lcd_rstb      (lcd_rstb),
    .lcd_dim       (lcd_dim),
    .video_gate    (video_gate),
    .panel_ready   (panel_ready),
    .fault         (fault),
    .state_o       (state_o)
  );

  typedef struct {
    int         cyc;
    logic [8:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   exp_hi[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  always @(posedge clk_50) cyc <= cyc + 1;

  // {pwr, rstb, gate, dim, ready, fault, state}
  function automatic logic [8:0] outs();
    return {lcd_power_ctl, lcd_rstb, video_gate, lcd_dim, panel_ready, fault, state_o};
  endfunction

  function automatic logic [8:0] v(input logic p, input logic r, input logic g, input logic d,
                                   input logic rd, input logic f, input logic [2:0] s);
    return {p, r, g, d, rd, f, s};
  endfunction

  task automatic push(input int c, input logic [8:0] val, input string nm);
    exp_t e;
    e.cyc = c; e.val = val; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic bring_up(output bit ok);
    ok = 1'b0;
    panel_en = 1'b1; vid_locked = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_50);
      if (state_o == 3'd4) begin ok = 1'b1; return; end
    end
  endtask

  task automatic bring_down(output bit ok);
    ok = 1'b0;
    panel_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_50);
      if (state_o == 3'd0 && fault == 1'b0) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; panel_en = 1'b0; vid_locked = 1'b0; bl_level = 8'd0;
    repeat (5) @(negedge clk_50);
    n_total++;
    if (outs() !== 9'd0) $display("FAIL reset_state: outputs %b, expected %b", outs(), 9'd0);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk_50);
    n_total++;
    if (outs() !== 9'd0) $display("FAIL idle_after_reset: outputs %b, expected %b", outs(), 9'd0);
    else n_pass++;
  endtask

  task automatic test_power_up();
    exp_t e; int c; int guard;
    bl_level = 8'd0; panel_en = 1'b1; vid_locked = 1'b1;
    c = cyc;
    push(c + 1,  v(1,0,0,0,0,0,3'd1), "pwr_on");
    push(c + 20, v(1,0,0,0,0,0,3'd1), "pwr_dwell_end");
    push(c + 21, v(1,1,0,0,0,0,3'd2), "rst_release");
    push(c + 30, v(1,1,0,0,0,0,3'd2), "rst_dwell_end");
    push(c + 31, v(1,1,1,0,0,0,3'd3), "video_on");
    push(c + 60, v(1,1,1,0,0,0,3'd3), "vid_dwell_end");
    push(c + 61, v(1,1,1,0,1,0,3'd4), "bl_on_ready");
    guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(negedge clk_50); guard++;
      if (cyc == sb[0].cyc) begin
        e = sb.pop_front(); n_total++;
        if (outs() !== e.val) $display("FAIL %s: cycle %0d outputs %b, expected %b", e.name, cyc, outs(), e.val);
        else n_pass++;
      end
    end
    if (sb.size() != 0) begin
      n_total++; $display("FAIL power_up_drain: %0d expectations left, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_power_down();
    exp_t e; int c; int guard; bit seen;
`ifndef MTL_BL_SOFT_RAMP_EN
    bl_level = 8'd255;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk_50);
      if (lcd_dim === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL dim_active_in_bl_on: dim %b, expected 1", lcd_dim);
    else n_pass++;
`endif
    panel_en = 1'b0;
    c = cyc;
    push(c + 1,  v(1,1,1,0,0,0,3'd5), "bl_off_dim_low");
    push(c + 30, v(1,1,1,0,0,0,3'd5), "bl_off_dwell_end");
    push(c + 31, v(1,0,0,0,0,0,3'd6), "vid_off");
    push(c + 40, v(1,0,0,0,0,0,3'd6), "vid_off_dwell_end");
    push(c + 41, v(0,0,0,0,0,0,3'd7), "pwr_dn");
    push(c + 60, v(0,0,0,0,0,0,3'd7), "pwr_dn_dwell_end");
    push(c + 61, v(0,0,0,0,0,0,3'd0), "off");
    guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(negedge clk_50); guard++;
      if (cyc == sb[0].cyc) begin
        e = sb.pop_front(); n_total++;
        if (outs() !== e.val) $display("FAIL %s: cycle %0d outputs %b, expected %b", e.name, cyc, outs(), e.val);
        else n_pass++;
      end
    end
    if (sb.size() != 0) begin
      n_total++; $display("FAIL power_down_drain: %0d expectations left, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_pwm();
    bit ok; bit found; logic prev; int hi; int bad; int want;
    bl_level = 8'd64;
    bring_up(ok);
    n_total++;
    if (!ok) $display("FAIL pwm_bring_up: state %0d, expected 4", state_o);
    else n_pass++;
    // Align to a period start: a rising edge of dim is pcnt wrapping to 0.
    prev = lcd_dim; found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk_50);
      if (prev === 1'b0 && lcd_dim === 1'b1) found = 1'b1;
      prev = lcd_dim;
    end
    n_total++;
    if (!found) $display("FAIL pwm_align: no dim rising edge, expected one within 600 cycles");
    else n_pass++;
    exp_hi.push_back(64);
    exp_hi.push_back(64);
    for (int p = 0; p < 3; p++) begin
      hi = 0; bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (p == 1 && i == 100) begin
          bl_level = 8'd192;
          exp_hi.push_back(192);
        end
        if (lcd_dim === 1'b1) hi++;
        if (p == 0 && lcd_dim !== (i < 64)) bad++;
        @(negedge clk_50);
      end
      want = exp_hi.pop_front();
      n_total++;
      if (hi != want) $display("FAIL pwm_duty_period%0d: high %0d cycles, expected %0d", p, hi, want);
      else n_pass++;
      if (p == 0) begin
        n_total++;
        if (bad != 0) $display("FAIL pwm_shape: %0d misplaced cycles, expected 0", bad);
        else n_pass++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      bl_level = (k == 0) ? 8'd0 : 8'd255;
      exp_hi.push_back((k == 0) ? 0 : 255);
      repeat (300) @(negedge clk_50);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        if (lcd_dim === 1'b1) hi++;
        @(negedge clk_50);
      end
      want = exp_hi.pop_front();
      n_total++;
      if (hi != want) $display("FAIL pwm_level_%0d: high %0d cycles, expected %0d", bl_level, hi, want);
      else n_pass++;
    end
    bring_down(ok);
    n_total++;
    if (!ok) $display("FAIL pwm_bring_down: state %0d, expected 0", state_o);
    else n_pass++;
  endtask

  task automatic test_fault();
    exp_t e; int c; int guard; bit ok;
    bl_level = 8'd0;
    bring_up(ok);
    n_total++;
    if (!ok) $display("FAIL fault_bring_up: state %0d, expected 4", state_o);
    else n_pass++;
    vid_locked = 1'b0;
    c = cyc;
    push(c + 1,  v(1,1,1,0,0,1,3'd5), "fault_set");
    push(c + 31, v(1,0,0,0,0,1,3'd6), "fault_vid_off");
    push(c + 41, v(0,0,0,0,0,1,3'd7), "fault_pwr_dn");
    push(c + 61, v(0,0,0,0,0,1,3'd0), "fault_off");
    for (int step = 0; step < 4; step++) begin
      if (step == 1) begin
        vid_locked = 1'b1;
        push(cyc + 5, v(0,0,0,0,0,1,3'd0), "fault_blocks_power_up");
      end else if (step == 2) begin
        panel_en = 1'b0;
        push(cyc + 1, v(0,0,0,0,0,0,3'd0), "fault_clear");
      end else if (step == 3) begin
        panel_en = 1'b1;
        push(cyc + 1, v(1,0,0,0,0,0,3'd1), "restart_after_fault");
      end
      guard = 0;
      while (sb.size() != 0 && guard < 400) begin
        @(negedge clk_50); guard++;
        if (cyc == sb[0].cyc) begin
          e = sb.pop_front(); n_total++;
          if (outs() !== e.val) $display("FAIL %s: cycle %0d outputs %b, expected %b", e.name, cyc, outs(), e.val);
          else n_pass++;
        end
      end
      if (sb.size() != 0) begin
        n_total++; $display("FAIL fault_drain: %0d expectations left, expected 0", sb.size()); sb.delete();
      end
    end
    bring_down(ok);
    n_total++;
    if (!ok) $display("FAIL fault_bring_down: state %0d, expected 0", state_o);
    else n_pass++;
  endtask

  task automatic test_abort();
    exp_t e; int c; int guard; bit ok;
    for (int step = 0; step < 6; step++) begin
      c = cyc;
      case (step)
        0: begin
          panel_en = 1'b1; vid_locked = 1'b1;
          push(c + 1, v(1,0,0,0,0,0,3'd1), "abort_pwr_up_entry");
          push(c + 5, v(1,0,0,0,0,0,3'd1), "abort_mid_pwr_up");
        end
        1: begin
          panel_en = 1'b0;
          push(c + 1,  v(0,0,0,0,0,0,3'd7), "abort_to_pwr_dn");
          push(c + 20, v(0,0,0,0,0,0,3'd7), "abort_pwr_dn_dwell");
          push(c + 21, v(0,0,0,0,0,0,3'd0), "abort_off");
        end
        2: begin
          panel_en = 1'b1;
          push(c + 31, v(1,1,1,0,0,0,3'd3), "abort_reach_vid_on");
        end
        3: begin
          panel_en = 1'b0;
          push(c + 1,  v(1,0,0,0,0,0,3'd6), "abort_vid_on_to_vid_off");
          push(c + 11, v(0,0,0,0,0,0,3'd7), "abort_vid_off_to_pwr_dn");
          push(c + 31, v(0,0,0,0,0,0,3'd0), "abort_vid_off_done");
        end
        4: begin
          bl_level = 8'd255;
          bring_up(ok);
          n_total++;
          if (!ok) $display("FAIL reset_bring_up: state %0d, expected 4", state_o);
          else n_pass++;
          repeat (3) @(negedge clk_50);
          reset_n = 1'b0;
          push(cyc + 1, v(0,0,0,0,0,0,3'd0), "reset_in_bl_on");
        end
        default: begin
          reset_n = 1'b1; panel_en = 1'b0;
          push(c + 1, v(0,0,0,0,0,0,3'd0), "idle_after_reset_release");
        end
      endcase
      guard = 0;
      while (sb.size() != 0 && guard < 400) begin
        @(negedge clk_50); guard++;
        if (cyc == sb[0].cyc) begin
          e = sb.pop_front(); n_total++;
          if (outs() !== e.val) $display("FAIL %s: cycle %0d outputs %b, expected %b", e.name, cyc, outs(), e.val);
          else n_pass++;
        end
      end
      if (sb.size() != 0) begin
        n_total++; $display("FAIL abort_drain: %0d expectations left, expected 0", sb.size()); sb.delete();
      end
    end
  endtask

`ifdef MTL_BL_SOFT_RAMP_EN
  task automatic test_soft_ramp();
    bit ok; int hi; int c; int fall; bit dim_seen; int want;
    bl_level = 8'd4;
    bring_up(ok);
    n_total++;
    if (!ok) $display("FAIL ramp_bring_up: state %0d, expected 4", state_o);
    else n_pass++;
    exp_hi.push_back(4);
    repeat (5 * 256) @(negedge clk_50);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (lcd_dim === 1'b1) hi++;
      @(negedge clk_50);
    end
    want = exp_hi.pop_front();
    n_total++;
    if (hi != want) $display("FAIL ramp_up_level: high %0d cycles, expected %0d", hi, want);
    else n_pass++;
    panel_en = 1'b0;
    c = cyc; fall = -1; dim_seen = 1'b0;
    for (int i = 0; i < 1200 && fall < 0; i++) begin
      @(negedge clk_50);
      if (lcd_dim === 1'b1) dim_seen = 1'b1;
      if (video_gate === 1'b0) fall = cyc - c;
    end
    n_total++;
    if (!dim_seen) $display("FAIL ramp_down_pwm_active: dim never high, expected high during ramp");
    else n_pass++;
    n_total++;
    if (fall < 800 || fall > 1055) $display("FAIL ramp_down_gate_fall: after %0d cycles, expected 800..1055", fall);
    else n_pass++;
    bring_down(ok);
    n_total++;
    if (!ok) $display("FAIL ramp_bring_down: state %0d, expected 0", state_o);
    else n_pass++;
  endtask
`endif

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk_50);
    test_reset();
    test_power_up();
    test_power_down();
`ifdef MTL_BL_SOFT_RAMP_EN
    test_soft_ramp();
`else
    test_pwm();
`endif
    test_fault();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
